// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Quotient reported on divide-by-zero; truncated to the instance width.
    localparam logic [63:0] DIV0_QUOTIENT = '1;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << bits) < 64'(value)) begin
                bits++;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/div_sub_cla.sv
// Trial subtractor a - b = a + ~b + 1, built from 4-bit carry-lookahead groups
// with the group carries chained; borrow is 1 when a < b (unsigned).
module div_sub_cla #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    localparam int NG = (W + 3) / 4;

    logic [W-1:0] g;
    logic [W-1:0] p;

    assign g = a & ~b;
    assign p = a ^ ~b;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int LO = 4 * k;
        localparam int N  = ((W - LO) < 4) ? (W - LO) : 4;

        logic         cin;
        logic         cout;
        logic [N:0]   cg;
        logic         acc;
        logic         run;

        if (k == 0) begin : g_first
            assign cin = 1'b1;
        end else begin : g_rest
            assign cin = g_grp[k-1].cout;
        end

        // Each carry is a flat sum of products over the group's g/p terms.
        // NOTE: every variable written here gets a value on every pass, so no latch is inferred.
        always_comb begin
            cg  = '0;
            acc = 1'b0;
            run = 1'b1;
            for (int j = 0; j <= N; j++) begin
                acc = 1'b0;
                run = 1'b1;
                for (int m = j - 1; m >= 0; m--) begin
                    acc = acc | (run & g[LO+m]);
                    run = run & p[LO+m];
                end
                cg[j] = acc | (run & cin);
            end
        end

        assign diff[LO +: N] = p[LO +: N] ^ cg[N-1:0];
        assign cout          = cg[N];
    end

    assign borrow = ~g_grp[NG-1].cout;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, start/done handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands (magnitude core + sign fix-up).
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] load_d;
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;
    logic             unused_diff_msb;

    assign accept = start && (state != CALC);
    assign trial  = {r_reg, q_reg[WIDTH-1]};

    div_sub_cla #(
        .W (WIDTH + 1)
    ) u_sub (
        .a      (trial),
        .b      ({1'b0, d_reg}),
        .diff   (diff),
        .borrow (borrow)
    );

    // R < D keeps the difference within WIDTH bits, so its MSB carries nothing.
    assign unused_diff_msb = diff[WIDTH];

    assign q_next = {q_reg[WIDTH-2:0], ~borrow};
    assign r_next = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];

`ifdef DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    assign load_q = dividend[WIDTH-1] ? -dividend : dividend;
    assign load_d = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign fix_q  = neg_q ? -q_next : q_next;
    assign fix_r  = neg_r ? -r_next : r_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign load_q = dividend;
    assign load_d = divisor;
    assign fix_q  = q_next;
    assign fix_r  = r_next;
`endif

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            // NOTE: working registers are reset too so an aborted division leaves no stale state.
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
            cnt         <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            quotient    <= WIDTH'(DIV0_QUOTIENT);
                            remainder   <= dividend;
                        end else begin
                            state       <= CALC;
                            busy        <= 1'b1;
                            div_by_zero <= 1'b0;
                            q_reg       <= load_q;
                            r_reg       <= '0;
                            d_reg       <= load_d;
                            cnt         <= '0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= fix_q;
                        remainder <= fix_r;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=32), hand-computed expectations.
module tb_seq_divider;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    int bcnt;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
    endtask

    // Counts edges from the accepting edge (n=1) until done is seen; lat=0 if the budget expires.
    task automatic wait_done(input int budget, input int pulse_at, input int rst_at,
                             output int latency, output int busy_cycles);
        latency     = 0;
        busy_cycles = 0;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) start = 1'b0;
            if (n == pulse_at + 1) start = 1'b0;
            if (n == rst_at + 1) rst = 1'b0;
            if (busy) busy_cycles++;
            if (done) begin
                latency = n;
                break;
            end
            if (n == pulse_at) begin
                dividend = 32'd50;
                divisor  = 32'd5;
                start    = 1'b1;
            end
            if (n == rst_at) rst = 1'b1;
        end
    endtask

    task automatic run_div(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] exp_q, input logic [WIDTH-1:0] exp_r);
        issue(a, b);
        wait_done(100, 0, 0, lat, bcnt);
        check({tag, "_lat"}, lat, 33);
        check({tag, "_q"}, quotient, exp_q);
        check({tag, "_r"}, remainder, exp_r);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);

        // Basic division with latency and busy-length checks.
        issue(32'd100, 32'd7);
        wait_done(100, 0, 0, lat, bcnt);
        check("d100_7_lat", lat, 33);
        check("d100_7_busy", bcnt, 32);
        check("d100_7_q", quotient, 14);
        check("d100_7_r", remainder, 2);
        check("d100_7_dbz", div_by_zero, 0);
        @(posedge clk);
        #1;
        check("done_pulse_one_cycle", done, 0);
        repeat (4) @(posedge clk);
        #1;
        check("hold_q", quotient, 14);
        check("hold_r", remainder, 2);

        run_div("max_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        run_div("d3_10", 32'd3, 32'd10, 32'd0, 32'd3);
        run_div("msb_msb", 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0);

        // Divide by zero: one-cycle latency, no busy.
        issue(32'd5, 32'd0);
        wait_done(100, 0, 0, lat, bcnt);
        check("div0_lat", lat, 1);
        check("div0_busy", bcnt, 0);
        check("div0_dbz", div_by_zero, 1);
        check("div0_q", quotient, 32'hFFFF_FFFF);
        check("div0_r", remainder, 5);
        issue(32'd9, 32'd3);
        wait_done(100, 0, 0, lat, bcnt);
        check("after0_lat", lat, 33);
        check("after0_dbz", div_by_zero, 0);
        check("after0_q", quotient, 3);

        // Start while busy is ignored; then back-to-back start held during done.
        issue(32'd100, 32'd7);
        wait_done(100, 10, 0, lat, bcnt);
        check("ign_lat", lat, 33);
        check("ign_q", quotient, 14);
        check("ign_r", remainder, 2);
        dividend = 32'd81;
        divisor  = 32'd9;
        start    = 1'b1;
        wait_done(100, 0, 0, lat, bcnt);
        check("b2b_lat", lat, 33);
        check("b2b_q", quotient, 9);
        check("b2b_r", remainder, 0);

        // Reset in the middle of a division aborts it.
        issue(32'd100, 32'd7);
        wait_done(40, 0, 15, lat, bcnt);
        check("abort_no_done", lat, 0);
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        check("abort_busy", busy, 0);
        run_div("d20_6", 32'd20, 32'd6, 32'd3, 32'd2);

`ifdef DIVIDER_SIGNED_EN
        run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
